sfft_seq_ctrl: RTL and testbench

- Run sequencer for the stochastic FFT butterfly array.
- Holds a small per-stage twiddle register file.
- On a start request, runs one complete transform:
  - one-cycle clear of all butterflies;
  - per-stage twiddle load (loadW pulses);
  - bitstream run of RUNLEN cycles with the enable asserted;
  - done pulse.
- Sits between the host/config logic and the butterfly array; drives its iEn, iClr, loadW, iwReal and iwImg.

---
 rtl/sfft_pkg.sv | 20 ++
 rtl/sfft_tw_regfile.sv | 47 ++++
 rtl/sfft_seq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sfft_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfft_pkg.sv
// Shared types and constants for the stochastic FFT run sequencer.
package sfft_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } sfft_state_e;

    localparam int SFFT_DEF_BITWIDTH = 8;
    localparam int SFFT_DEF_RUNLEN   = 1 << SFFT_DEF_BITWIDTH;

    // A single-stage transform still needs a one-bit index.
    function automatic int sfft_stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/sfft_tw_regfile.sv
// Per-stage twiddle storage: gated write port, combinational read by stage index.
module sfft_tw_regfile #(
    parameter int BITWIDTH = 8,
    parameter int LOG2N    = 2,
    parameter int SW       = 1
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iWe,
    input  logic [SW-1:0]       iWrAddr,
    input  logic [BITWIDTH-1:0] iWrReal,
    input  logic [BITWIDTH-1:0] iWrImg,
    input  logic [SW-1:0]       iRdAddr,
    output logic [BITWIDTH-1:0] oRdReal,
    output logic [BITWIDTH-1:0] oRdImg
);

    logic [BITWIDTH-1:0] real_r [LOG2N];
    logic [BITWIDTH-1:0] img_r  [LOG2N];

    // Twiddle storage; indices beyond the stage count are dropped.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < LOG2N; i++) begin
                real_r[i] <= '0;
                img_r[i]  <= '0;
            end
        end else if (iWe && (int'(iWrAddr) < LOG2N)) begin
            real_r[iWrAddr] <= iWrReal;
            img_r[iWrAddr]  <= iWrImg;
        end
    end

    // Read port for the sequencer.
    always_comb begin
        oRdReal = '0;
        oRdImg  = '0;
        if (int'(iRdAddr) < LOG2N) begin
            oRdReal = real_r[iRdAddr];
            oRdImg  = img_r[iRdAddr];
        end else begin
            oRdReal = '0;
            oRdImg  = '0;
        end
    end

endmodule

// File: rtl/sfft_seq_ctrl.sv
// Run sequencer for the stochastic FFT butterfly array: clear, twiddle load, bitstream run, done.
// Optional per-run length input enabled by defining SFFT_CTRL_RUNLEN_EN.
module sfft_seq_ctrl
    import sfft_pkg::*;
#(
    parameter int  BITWIDTH = 8,
    parameter int  LOG2N    = 2,
    localparam int SW       = sfft_stage_w(LOG2N)
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
`ifdef SFFT_CTRL_RUNLEN_EN
    input  logic [BITWIDTH:0]   iRunLen,
`endif
    output logic                oReady,
    input  logic                iAbort,
    input  logic                iTwWe,
    input  logic [SW-1:0]       iTwAddr,
    input  logic [BITWIDTH-1:0] iTwReal,
    input  logic [BITWIDTH-1:0] iTwImg,
    output logic                oClr,
    output logic                oLoadW,
    output logic [SW-1:0]       oStage,
    output logic [BITWIDTH-1:0] oWReal,
    output logic [BITWIDTH-1:0] oWImg,
    output logic                oEn,
    output logic [BITWIDTH:0]   oCycCnt,
    output logic                oDone
);

    localparam logic [BITWIDTH:0] RUNLEN_DEF = {1'b1, {BITWIDTH{1'b0}}};
    localparam logic [BITWIDTH:0] CNT_ONE    = (BITWIDTH+1)'(1);
    localparam logic [SW-1:0]     LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [SW-1:0]     STAGE_ONE  = SW'(1);

    sfft_state_e         state_r;
    logic [SW-1:0]       stage_r;
    logic [BITWIDTH:0]   runlen_r;
    logic [BITWIDTH:0]   runlen_sel_s;
    logic [SW-1:0]       rd_addr_s;
    logic [BITWIDTH-1:0] rd_real_s;
    logic [BITWIDTH-1:0] rd_img_s;
    logic                tw_we_s;

    // Host writes land only while idle, so a run always sees a stable table.
    assign tw_we_s = iTwWe & oReady;

    sfft_tw_regfile #(
        .BITWIDTH(BITWIDTH),
        .LOG2N   (LOG2N),
        .SW      (SW)
    ) u_tw (
        .iClk   (iClk),
        .iRst   (iRst),
        .iWe    (tw_we_s),
        .iWrAddr(iTwAddr),
        .iWrReal(iTwReal),
        .iWrImg (iTwImg),
        .iRdAddr(rd_addr_s),
        .oRdReal(rd_real_s),
        .oRdImg (rd_img_s)
    );

`ifdef SFFT_CTRL_RUNLEN_EN
    // A zero request selects the full 2^BITWIDTH run.
    always_comb begin
        runlen_sel_s = RUNLEN_DEF;
        if (iRunLen == '0) begin
            runlen_sel_s = RUNLEN_DEF;
        end else begin
            runlen_sel_s = iRunLen;
        end
    end
`else
    assign runlen_sel_s = RUNLEN_DEF;
`endif

    // Read address looks one stage ahead because the load outputs are registered.
    always_comb begin
        rd_addr_s = '0;
        if (state_r == LOAD) begin
            rd_addr_s = stage_r + STAGE_ONE;
        end else begin
            rd_addr_s = '0;
        end
    end

    // Sequencer state, counter and registered array controls.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r  <= IDLE;
            stage_r  <= '0;
            runlen_r <= RUNLEN_DEF;
            oReady   <= 1'b1;
            oClr     <= 1'b0;
            oLoadW   <= 1'b0;
            oStage   <= '0;
            oWReal   <= '0;
            oWImg    <= '0;
            oEn      <= 1'b0;
            oCycCnt  <= '0;
            oDone    <= 1'b0;
        end else if (iAbort && (state_r != IDLE)) begin
            state_r <= IDLE;
            stage_r <= '0;
            oReady  <= 1'b1;
            oClr    <= 1'b0;
            oLoadW  <= 1'b0;
            oStage  <= '0;
            oWReal  <= '0;
            oWImg   <= '0;
            oEn     <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iStart) begin
                        state_r  <= CLR;
                        runlen_r <= runlen_sel_s;
                        oReady   <= 1'b0;
                        oClr     <= 1'b1;
                        oCycCnt  <= '0;
                    end
                end
                CLR: begin
                    state_r <= LOAD;
                    stage_r <= '0;
                    oClr    <= 1'b0;
                    oLoadW  <= 1'b1;
                    oStage  <= '0;
                    oWReal  <= rd_real_s;
                    oWImg   <= rd_img_s;
                end
                LOAD: begin
                    if (stage_r == LAST_STAGE) begin
                        state_r <= RUN;
                        stage_r <= '0;
                        oLoadW  <= 1'b0;
                        oStage  <= '0;
                        oWReal  <= '0;
                        oWImg   <= '0;
                        oEn     <= 1'b1;
                        oCycCnt <= '0;
                    end else begin
                        stage_r <= stage_r + STAGE_ONE;
                        oStage  <= stage_r + STAGE_ONE;
                        oWReal  <= rd_real_s;
                        oWImg   <= rd_img_s;
                    end
                end
                RUN: begin
                    if (oCycCnt == (runlen_r - CNT_ONE)) begin
                        state_r <= DONE;
                        oEn     <= 1'b0;
                        oDone   <= 1'b1;
                        oCycCnt <= runlen_r;
                    end else begin
                        oCycCnt <= oCycCnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    oDone   <= 1'b0;
                    oReady  <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    stage_r <= '0;
                    oReady  <= 1'b1;
                    oClr    <= 1'b0;
                    oLoadW  <= 1'b0;
                    oStage  <= '0;
                    oWReal  <= '0;
                    oWImg   <= '0;
                    oEn     <= 1'b0;
                    oDone   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfft_seq_ctrl.sv
// Self-checking bench for sfft_seq_ctrl against a cycle-timeline reference model.
module tb_sfft_seq_ctrl;

    localparam int L = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, tw_we;
    logic [0:0] tw_addr;
    logic [7:0] tw_re, tw_im;
    logic       ready, clr, loadw, en, done;
    logic [0:0] stage;
    logic [7:0] wr, wi;
    logic [8:0] cnt;
`ifdef SFFT_CTRL_RUNLEN_EN
    logic [8:0] runlen;
`endif

    logic       start3, abort3, tw_we3;
    logic [1:0] tw_addr3;
    logic [7:0] tw_re3, tw_im3;
    logic       ready3, clr3, loadw3, en3, done3;
    logic [1:0] stage3;
    logic [7:0] wr3, wi3;
    logic [8:0] cnt3;

    int checks = 0;
    int errors = 0;
    int m_re [L];
    int m_im [L];
    int m3_re [3];
    int m3_im [3];

    always #5 clk = ~clk;

    sfft_seq_ctrl #(.BITWIDTH(8), .LOG2N(L)) dut (
        .iClk(clk), .iRst(rst), .iStart(start),
`ifdef SFFT_CTRL_RUNLEN_EN
        .iRunLen(runlen),
`endif
        .oReady(ready), .iAbort(abort), .iTwWe(tw_we), .iTwAddr(tw_addr),
        .iTwReal(tw_re), .iTwImg(tw_im), .oClr(clr), .oLoadW(loadw), .oStage(stage),
        .oWReal(wr), .oWImg(wi), .oEn(en), .oCycCnt(cnt), .oDone(done)
    );

    sfft_seq_ctrl #(.BITWIDTH(8), .LOG2N(3)) dut3 (
        .iClk(clk), .iRst(rst), .iStart(start3),
`ifdef SFFT_CTRL_RUNLEN_EN
        .iRunLen(9'd0),
`endif
        .oReady(ready3), .iAbort(abort3), .iTwWe(tw_we3), .iTwAddr(tw_addr3),
        .iTwReal(tw_re3), .iTwImg(tw_im3), .oClr(clr3), .oLoadW(loadw3), .oStage(stage3),
        .oWReal(wr3), .oWImg(wi3), .oEn(en3), .oCycCnt(cnt3), .oDone(done3)
    );

    task automatic tw_write(input int addr, input int re, input int im);
        tw_we   = 1'b1;
        tw_addr = addr[0:0];
        tw_re   = re[7:0];
        tw_im   = im[7:0];
        @(negedge clk);
        tw_we = 1'b0;
        m_re[addr] = re & 255;
        m_im[addr] = im & 255;
    endtask

    // Start a run and compare every cycle against the CLR / LOAD x L / RUN x rl / DONE timeline.
    task automatic run_check(input int rl_in, input int abort_at, input bit junk);
        int rl, s, e_cnt, seen;
        bit e_clr, e_load, e_en, e_done;
        logic [13:0] obs, exp_v;
`ifdef SFFT_CTRL_RUNLEN_EN
        rl = (rl_in == 0) ? 256 : rl_in;
        runlen = rl_in[8:0];
`else
        rl = 256;
        if (rl_in != 0) $display("note: run length %0d requested without runlen support, using 256", rl_in);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tw_we = 1'b0;
        for (int c = 1; c <= 2 + L + rl; c++) begin
            e_clr  = (c == 1);
            e_load = (c >= 2) && (c <= 1 + L);
            e_en   = (c >= 2 + L) && (c <= 1 + L + rl);
            e_done = (c == 2 + L + rl);
            e_cnt  = e_en ? (c - 2 - L) : (e_done ? rl : 0);
            obs    = {ready, clr, loadw, en, done, cnt};
            exp_v  = {1'b0, e_clr, e_load, e_en, e_done, e_cnt[8:0]};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_ctrl cycle %0d: got %h expected %h", c, obs, exp_v);
            end
            if (e_load) begin
                s = c - 2;
                checks++;
                if ({stage, wr, wi} !== {s[0], m_re[s][7:0], m_im[s][7:0]}) begin
                    errors++;
                    $display("FAIL load_stage %0d: got %h/%h/%h expected %0d/%h/%h",
                             s, stage, wr, wi, s, m_re[s], m_im[s]);
                end
            end
            if (e_en && ((c - 2 - L) == abort_at)) begin
                abort = 1'b1;
                start = 1'b0;
                tw_we = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                checks++;
                if ({ready, clr, loadw, en, done} !== 5'b10000) begin
                    errors++;
                    $display("FAIL abort_idle: got %b expected 10000", {ready, clr, loadw, en, done});
                end
                seen = 0;
                repeat (rl + 8) begin
                    @(negedge clk);
                    if (done) seen = 1;
                end
                checks++;
                if (seen != 0) begin
                    errors++;
                    $display("FAIL abort_no_done: got done seen=%0d expected 0", seen);
                end
                return;
            end
            if (junk && (c < 1 + L + rl)) begin
                start   = (c % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                tw_we   = 1'b1;
                tw_addr = (c % 2 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                tw_re   = (c % 2 == 1) ? 8'hFF : 8'($urandom);
                tw_im   = (c % 2 == 1) ? 8'hFF : 8'($urandom);
`ifdef SFFT_CTRL_RUNLEN_EN
                runlen  = 9'($urandom);
`endif
            end else begin
                start = 1'b0;
                tw_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        tw_we = 1'b0;
        checks++;
        if ({ready, en, done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_run: got %b expected 100", {ready, en, done});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, clr, loadw, en, done, cnt} !== {5'b10000, 9'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", {ready, clr, loadw, en, done, cnt}, {5'b10000, 9'd0});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_run;
        tw_write(0, 'h80, 'h00);
        tw_write(1, 'h00, 'h80);
        run_check(0, -1, 1'b0);
    endtask

    task automatic test_busy_reject;
        run_check(0, -1, 1'b1);
        run_check(0, -1, 1'b0);
    endtask

    task automatic test_start_with_write;
        int re, im;
        re = $urandom_range(0, 255);
        im = $urandom_range(0, 255);
        tw_we = 1'b1; tw_addr = 1'b1; tw_re = re[7:0]; tw_im = im[7:0];
        m_re[1] = re; m_im[1] = im;
        run_check(0, -1, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 2; k++) begin
            tw_write(k, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        run_check($urandom_range(1, 40), -1, 1'b0);
        run_check($urandom_range(1, 40), -1, 1'b1);
    endtask

    task automatic test_abort;
        run_check(0, 100, 1'b0);
        run_check(0, $urandom_range(0, 255), 1'b1);
    endtask

    task automatic test_reset_midrun;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, clr, loadw, en, done, cnt} !== {5'b10000, 9'd0}) begin
            errors++;
            $display("FAIL reset_midrun: got %h expected %h", {ready, clr, loadw, en, done, cnt}, {5'b10000, 9'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < L; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
        @(negedge clk);
        run_check(0, -1, 1'b0);
    endtask

    task automatic test_out_of_range;
        for (int a = 0; a < 3; a++) begin
            m3_re[a] = $urandom_range(0, 254);
            m3_im[a] = $urandom_range(0, 254);
            tw_we3 = 1'b1; tw_addr3 = 2'(a); tw_re3 = 8'(m3_re[a]); tw_im3 = 8'(m3_im[a]);
            @(negedge clk);
        end
        tw_we3 = 1'b1; tw_addr3 = 2'd3; tw_re3 = 8'hFF; tw_im3 = 8'hFF;
        @(negedge clk);
        tw_we3 = 1'b0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        checks++;
        if ({ready3, clr3, loadw3} !== 3'b010) begin
            errors++;
            $display("FAIL l3_clr: got %b expected 010", {ready3, clr3, loadw3});
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if ({loadw3, stage3, wr3, wi3, cnt3} !== {1'b1, 2'(s), 8'(m3_re[s]), 8'(m3_im[s]), 9'd0}) begin
                errors++;
                $display("FAIL l3_load %0d: got %h/%h/%h expected %h/%h", s, stage3, wr3, wi3, m3_re[s], m3_im[s]);
            end
        end
        @(negedge clk);
        checks++;
        if ({en3, loadw3, cnt3} !== {2'b10, 9'd0}) begin
            errors++;
            $display("FAIL l3_run_start: got %b/%b/%0d expected 1/0/0", en3, loadw3, cnt3);
        end
        abort3 = 1'b1;
        @(negedge clk);
        abort3 = 1'b0;
        checks++;
        if ({ready3, en3, done3} !== 3'b100) begin
            errors++;
            $display("FAIL l3_abort: got %b expected 100", {ready3, en3, done3});
        end
    endtask

`ifdef SFFT_CTRL_RUNLEN_EN
    task automatic test_runlen;
        run_check(16, -1, 1'b0);
        run_check(0, -1, 1'b0);
        run_check($urandom_range(1, 60), -1, 1'b1);
    endtask
`endif

    initial begin
        start = 1'b0; abort = 1'b0; tw_we = 1'b0; tw_addr = '0; tw_re = '0; tw_im = '0;
        start3 = 1'b0; abort3 = 1'b0; tw_we3 = 1'b0; tw_addr3 = '0; tw_re3 = '0; tw_im3 = '0;
`ifdef SFFT_CTRL_RUNLEN_EN
        runlen = 9'd0;
`endif
        for (int k = 0; k < L; k++) begin
            m_re[k] = 0;
            m_im[k] = 0;
        end
        test_reset;
        test_full_run;
        test_busy_reject;
        test_start_with_write;
        test_back_to_back;
        test_abort;
        test_reset_midrun;
        test_out_of_range;
`ifdef SFFT_CTRL_RUNLEN_EN
        test_runlen;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
